// File: rtl/if_fetch_stage_if.sv
// Bundle of the fetch-stage signals: ID-stage redirect/hazard controls,
// instruction-memory address/data, and the IF/ID pipeline register outputs.
// The fetch stage uses the master view; the ID stage / memory side uses slave.
interface if_fetch_stage_if;
    logic        Stall;
    logic        PCSrc;
    logic        Jump;
    logic        If_Id_Flush;
    logic [31:0] Branch_Target;
    logic [31:0] Jump_Target;
    logic [31:0] Imem_Data;
    logic [31:0] Imem_Addr;
    logic [31:0] If_Id_Instr;
    logic [31:0] If_Id_PC4;
    logic        If_Id_Valid;
    logic [31:0] Fetch_Count;

    modport master (
        input  Stall, PCSrc, Jump, If_Id_Flush,
        input  Branch_Target, Jump_Target, Imem_Data,
        output Imem_Addr, If_Id_Instr, If_Id_PC4, If_Id_Valid, Fetch_Count
    );

    modport slave (
        output Stall, PCSrc, Jump, If_Id_Flush,
        output Branch_Target, Jump_Target, Imem_Data,
        input  Imem_Addr, If_Id_Instr, If_Id_PC4, If_Id_Valid, Fetch_Count
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection (jump > branch > +4),
// IF/ID pipeline register with squash on redirect/flush, delivered-instruction
// counter, and a boot sequencer that holds fetch for BOOT_CYCLES after reset.
// Optional macro DELAY_SLOT_EN: a redirect keeps the instruction fetched in the
// redirect cycle (MIPS delay slot) instead of squashing it.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0000,
    parameter int unsigned BOOT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    if_fetch_stage_if.master bus
);

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [3:0] BOOT_INIT = 4'(BOOT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  boot_cnt_q, boot_cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q, count_d;

    logic [31:0] pc_plus4;
    logic        redirect;
    logic        squash;

    assign pc_plus4 = pc_q + 32'd4;
    assign redirect = (bus.Jump | bus.PCSrc) & ~bus.Stall;

`ifdef DELAY_SLOT_EN
    // The redirect-cycle instruction is a delay slot and is kept.
    assign squash = bus.If_Id_Flush;
`else
    // The redirect-cycle instruction is wrong-path and becomes a bubble.
    assign squash = bus.If_Id_Flush | redirect;
`endif

    assign bus.Imem_Addr   = pc_q;
    assign bus.If_Id_Instr = instr_q;
    assign bus.If_Id_PC4   = pc4_q;
    assign bus.If_Id_Valid = valid_q;
    assign bus.Fetch_Count = count_q;

    // Next-state logic: boot countdown, PC selection and IF/ID load.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;
        count_d    = count_q;

        case (state_q)
            ST_BOOT: begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
                if (boot_cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q - 4'd1;
                end
            end
            ST_RUN: begin
                if (!bus.Stall) begin
                    if (redirect) begin
                        pc_d = bus.Jump ? bus.Jump_Target : bus.Branch_Target;
                    end else begin
                        pc_d = pc_plus4;
                    end
                    pc4_d = pc_plus4;
                    if (squash) begin
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                    end else begin
                        instr_d = bus.Imem_Data;
                        valid_d = 1'b1;
                        count_d = count_q + 32'd1;
                    end
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= BOOT_INIT;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            pc4_q      <= RESET_PC;
            valid_q    <= 1'b0;
            count_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc4_q      <= pc4_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: boot sequence, a directed vector
// table (sequential fetch, branch, priority, stall, flush, wrap), a mid-run
// reset sequence, then randomized traffic against a behavioural model.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;
`ifdef DELAY_SLOT_EN
    localparam int DS    = 1;
    localparam bit DS_EN = 1'b1;
`else
    localparam int DS    = 0;
    localparam bit DS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    if_fetch_stage_if bus ();

    if_fetch_stage #(
        .RESET_PC    (32'h0000_0000),
        .NOP_INSTR   (NOP),
        .BOOT_CYCLES (2)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // Instruction memory: a fixed hash of the address, never equal to NOP at 0.
    function automatic logic [31:0] imem_fn(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    assign bus.Imem_Data = imem_fn(bus.Imem_Addr);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic stall, input logic pcsrc, input logic jump,
                         input logic flush, input logic [31:0] bt, input logic [31:0] jt);
        bus.Stall         = stall;
        bus.PCSrc         = pcsrc;
        bus.Jump          = jump;
        bus.If_Id_Flush   = flush;
        bus.Branch_Target = bt;
        bus.Jump_Target   = jt;
    endtask

    task automatic check_all(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                             input logic [31:0] pc4, input logic valid, input logic [31:0] cnt);
        check({tag, ".addr"},  bus.Imem_Addr,          addr);
        check({tag, ".instr"}, bus.If_Id_Instr,        instr);
        check({tag, ".pc4"},   bus.If_Id_PC4,          pc4);
        check({tag, ".valid"}, 32'(bus.If_Id_Valid),   32'(valid));
        check({tag, ".count"}, bus.Fetch_Count,        cnt);
    endtask

    typedef struct {
        logic        stall;
        logic        pcsrc;
        logic        jump;
        logic        flush;
        logic [31:0] bt;
        logic [31:0] jt;
        logic [31:0] e_addr;
        logic        e_nop;
        logic [31:0] e_iaddr;
        logic [31:0] e_pc4;
        logic        e_valid;
        int          e_count;
    } vec_t;

    function automatic vec_t mk(input logic stall, input logic pcsrc, input logic jump,
                                input logic flush, input logic [31:0] bt, input logic [31:0] jt,
                                input logic [31:0] e_addr, input logic e_nop,
                                input logic [31:0] e_iaddr, input logic [31:0] e_pc4,
                                input logic e_valid, input int e_count);
        vec_t v;
        v.stall = stall; v.pcsrc = pcsrc; v.jump = jump; v.flush = flush;
        v.bt = bt; v.jt = jt; v.e_addr = e_addr; v.e_nop = e_nop;
        v.e_iaddr = e_iaddr; v.e_pc4 = e_pc4; v.e_valid = e_valid; v.e_count = e_count;
        return v;
    endfunction

    vec_t vecs[12];

    // Behavioural model state for the random phase.
    logic [31:0] m_pc, m_instr, m_pc4, m_count;
    logic        m_valid;
    int          m_boot_wait;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                stall pcsrc jump flush bt          jt            addr          nop     iaddr         pc4           valid  count
        vecs[0]  = mk(0, 0, 0, 0, 32'h0,       32'h0,        32'h8,        0,      32'h4,        32'h8,        1,     2);
        vecs[1]  = mk(0, 1, 0, 0, 32'h40,      32'h0,        32'h40,       !DS_EN, 32'h8,        32'hC,        DS_EN, 2 + DS);
        vecs[2]  = mk(0, 0, 0, 0, 32'h0,       32'h0,        32'h44,       0,      32'h40,       32'h44,       1,     3 + DS);
        vecs[3]  = mk(0, 1, 1, 0, 32'h200,     32'h100,      32'h100,      !DS_EN, 32'h44,       32'h48,       DS_EN, 3 + 2*DS);
        vecs[4]  = mk(1, 1, 1, 0, 32'h200,     32'h100,      32'h100,      !DS_EN, 32'h44,       32'h48,       DS_EN, 3 + 2*DS);
        vecs[5]  = mk(1, 0, 0, 1, 32'h0,       32'h0,        32'h100,      !DS_EN, 32'h44,       32'h48,       DS_EN, 3 + 2*DS);
        vecs[6]  = mk(0, 0, 0, 1, 32'h0,       32'h0,        32'h104,      1,      32'h0,        32'h104,      0,     3 + 2*DS);
        vecs[7]  = mk(0, 0, 0, 0, 32'h0,       32'h0,        32'h108,      0,      32'h104,      32'h108,      1,     4 + 2*DS);
        vecs[8]  = mk(0, 0, 1, 0, 32'h0,       32'hFFFF_FFFC, 32'hFFFF_FFFC, !DS_EN, 32'h108,    32'h10C,      DS_EN, 4 + 3*DS);
        vecs[9]  = mk(0, 0, 0, 0, 32'h0,       32'h0,        32'h0,        0,      32'hFFFF_FFFC, 32'h0,       1,     5 + 3*DS);
        vecs[10] = mk(0, 0, 1, 1, 32'h0,       32'h3C,       32'h3C,       1,      32'h0,        32'h4,        0,     5 + 3*DS);
        vecs[11] = mk(0, 0, 0, 0, 32'h0,       32'h0,        32'h40,       0,      32'h3C,       32'h40,       1,     6 + 3*DS);

        // Reset held for two edges, with redirect inputs active.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h200, 32'h300);
        rst_n = 1'b0;
        tick();
        tick();
        check_all("reset", 32'h0, NOP, 32'h0, 1'b0, 32'd0);

        // Boot: two edges with fetch held, third edge is the first fetch.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;
        tick();
        check_all("boot1", 32'h0, NOP, 32'h0, 1'b0, 32'd0);
        tick();
        check_all("boot2", 32'h0, NOP, 32'h0, 1'b0, 32'd0);
        tick();
        check_all("fetch0", 32'h4, imem_fn(32'h0), 32'h4, 1'b1, 32'd1);

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].stall, vecs[i].pcsrc, vecs[i].jump, vecs[i].flush, vecs[i].bt, vecs[i].jt);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].e_addr,
                      vecs[i].e_nop ? NOP : imem_fn(vecs[i].e_iaddr),
                      vecs[i].e_pc4, vecs[i].e_valid, 32'(vecs[i].e_count));
        end

        // Mid-run reset at PC=0x40 with Valid=1, then inputs ignored during boot.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h600, 32'h500);
        rst_n = 1'b0;
        tick();
        check_all("midrst", 32'h0, NOP, 32'h0, 1'b0, 32'd0);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h600, 32'h500);
        tick();
        check_all("mboot1", 32'h0, NOP, 32'h0, 1'b0, 32'd0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h600, 32'h500);
        tick();
        check_all("mboot2", 32'h0, NOP, 32'h0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check_all("mfetch0", 32'h4, imem_fn(32'h0), 32'h4, 1'b1, 32'd1);

        // Randomized traffic against the behavioural model.
        m_pc = 32'h4; m_instr = imem_fn(32'h0); m_pc4 = 32'h4;
        m_valid = 1'b1; m_count = 32'd1; m_boot_wait = 0;
        for (int n = 0; n < 400; n++) begin
            logic stall, pcsrc, jump, flush, do_rst, keep;
            logic [31:0] bt, jt;
            stall  = ($urandom % 5) == 0;
            pcsrc  = ($urandom % 4) == 0;
            jump   = ($urandom % 6) == 0;
            flush  = ($urandom % 7) == 0;
            do_rst = ($urandom % 60) == 0;
            bt = (($urandom % 8) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
            jt = (($urandom % 8) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            drive(stall, pcsrc, jump, flush, bt, jt);
            rst_n = ~do_rst;

            if (do_rst) begin
                m_pc = 32'h0; m_instr = NOP; m_pc4 = 32'h0;
                m_valid = 1'b0; m_count = 32'd0; m_boot_wait = 2;
            end else if (m_boot_wait > 0) begin
                m_boot_wait--;
                m_instr = NOP;
                m_valid = 1'b0;
            end else if (!stall) begin
                keep    = !flush && (DS_EN || !(jump || pcsrc));
                m_instr = keep ? imem_fn(m_pc) : NOP;
                m_valid = keep;
                m_pc4   = m_pc + 32'd4;
                if (keep) m_count = m_count + 32'd1;
                m_pc = jump ? jt : (pcsrc ? bt : m_pc + 32'd4);
            end

            tick();
            check_all($sformatf("rnd%0d", n), m_pc, m_instr, m_pc4, m_valid, m_count);
        end
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
